// File: rtl/hc_pkg.sv
// rtl/hc_pkg.sv - shared types and constants for the loopback write engine
// Purpose: write-engine state encoding and the request tag width.
package hc_pkg;

  localparam int MDATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_t;

endpackage

// File: rtl/loopback_wr_engine.sv
// rtl/loopback_wr_engine.sv - drains the loopback FIFO into single-line memory writes
// Purpose: pops one 512-bit line per issue, emits a registered write request to
//   base + index, throttles on host almost-full and an outstanding-write limit,
//   counts acknowledgements and reports completion once all writes are acked.
// Ports:
//   clk, reset (async, active-low)
//   start, wr_base_addr, num_lines          job launch (accepted in IDLE/DONE)
//   fifo_deq_data, fifo_not_empty, fifo_deq_en   FIFO dequeue port
//   wr_almost_full, wr_req_valid/addr/data/mdata   host write request channel
//   wr_rsp_valid                             one write acknowledged
//   busy, done, lines_written                status
module loopback_wr_engine
  import hc_pkg::*;
#(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 42,
  parameter int LEN_WIDTH       = 32,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  wr_base_addr,
  input  logic [LEN_WIDTH-1:0]   num_lines,
  input  logic [DATA_WIDTH-1:0]  fifo_deq_data,
  input  logic                   fifo_not_empty,
  output logic                   fifo_deq_en,
  input  logic                   wr_almost_full,
  output logic                   wr_req_valid,
  output logic [ADDR_WIDTH-1:0]  wr_req_addr,
  output logic [DATA_WIDTH-1:0]  wr_req_data,
  output logic [MDATA_WIDTH-1:0] wr_req_mdata,
  input  logic                   wr_rsp_valid,
  output logic                   busy,
  output logic                   done,
  output logic [LEN_WIDTH-1:0]   lines_written
);

  // One extra bit so the counter can hold MAX_OUTSTANDING itself.
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  wr_state_t              state_q;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   sent_q;
  logic [OW-1:0]          outstanding_q;
  logic [OW-1:0]          outstanding_d;
  logic [LEN_WIDTH-1:0]   lines_written_q;
  logic                   req_valid_q;
  logic [ADDR_WIDTH-1:0]  req_addr_q;
  logic [DATA_WIDTH-1:0]  req_data_q;
  logic [MDATA_WIDTH-1:0] req_mdata_q;
  logic                   busy_q;
  logic                   done_q;

  logic issue;
  logic rsp_hit;
  logic active;

  assign active = (state_q == ST_WRITE) || (state_q == ST_DRAIN);

  assign issue = (state_q == ST_WRITE) && fifo_not_empty && !wr_almost_full &&
                 (outstanding_q < OW'(MAX_OUTSTANDING)) && (sent_q < len_q);

  // Acks outside an active job, or with nothing in flight, are dropped.
  assign rsp_hit = wr_rsp_valid && active && (outstanding_q != '0);

  always_comb begin
    outstanding_d = outstanding_q;
    if (issue && !rsp_hit) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!issue && rsp_hit) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      base_q          <= '0;
      len_q           <= '0;
      sent_q          <= '0;
      outstanding_q   <= '0;
      lines_written_q <= '0;
      req_valid_q     <= 1'b0;
      req_addr_q      <= '0;
      req_data_q      <= '0;
      req_mdata_q     <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      req_valid_q   <= issue;
      outstanding_q <= outstanding_d;

      if (issue) begin
        req_data_q  <= fifo_deq_data;
        req_addr_q  <= base_q + ADDR_WIDTH'(sent_q);
        req_mdata_q <= sent_q[MDATA_WIDTH-1:0];
        sent_q      <= sent_q + 1'b1;
      end

      if (rsp_hit) begin
        lines_written_q <= lines_written_q + 1'b1;
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            base_q          <= wr_base_addr;
            len_q           <= num_lines;
            sent_q          <= '0;
            outstanding_q   <= '0;
            lines_written_q <= '0;
            if (num_lines == '0) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_WRITE;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        ST_WRITE: begin
          if (sent_q == len_q) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Look at the next-cycle count so done follows the last ack directly.
          if (outstanding_d == '0) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fifo_deq_en   = issue;
  assign wr_req_valid  = req_valid_q;
  assign wr_req_addr   = req_addr_q;
  assign wr_req_data   = req_data_q;
  assign wr_req_mdata  = req_mdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign lines_written = lines_written_q;

endmodule

// File: tb/tb_loopback_wr_engine.sv
// tb/tb_loopback_wr_engine.sv - directed self-checking bench for loopback_wr_engine
module tb_loopback_wr_engine;

  localparam int DW = 512;
  localparam int AW = 42;
  localparam int LW = 32;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] wr_base_addr = '0;
  logic [LW-1:0] num_lines = '0;
  logic [DW-1:0] fifo_deq_data = '0;
  logic          fifo_not_empty = 1'b0;
  logic          fifo_deq_en;
  logic          wr_almost_full = 1'b0;
  logic          wr_req_valid;
  logic [AW-1:0] wr_req_addr;
  logic [DW-1:0] wr_req_data;
  logic [15:0]   wr_req_mdata;
  logic          wr_rsp_valid = 1'b0;
  logic          busy;
  logic          done;
  logic [LW-1:0] lines_written;

  loopback_wr_engine #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .wr_base_addr(wr_base_addr), .num_lines(num_lines),
    .fifo_deq_data(fifo_deq_data), .fifo_not_empty(fifo_not_empty),
    .fifo_deq_en(fifo_deq_en), .wr_almost_full(wr_almost_full),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr),
    .wr_req_data(wr_req_data), .wr_req_mdata(wr_req_mdata),
    .wr_rsp_valid(wr_rsp_valid), .busy(busy), .done(done),
    .lines_written(lines_written)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO model
  logic [DW-1:0] fq[$];
  bit            pend_pop = 0;

  function automatic void refresh();
    fifo_not_empty = (fq.size() > 0);
    fifo_deq_data  = (fq.size() > 0) ? fq[0] : '0;
  endfunction

  function automatic logic [DW-1:0] pat(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {16{w}};
  endfunction

  task automatic push(input logic [DW-1:0] d);
    fq.push_back(d);
    refresh();
  endtask

  // Monitor
  logic [AW-1:0] cap_addr[$];
  logic [15:0]   cap_md[$];
  logic [DW-1:0] cap_data[$];
  int            cap_cyc[$];
  int            cyc = 0;
  int            win_deq = 0;
  int            win_req = 0;
  bit            auto_rsp = 0;
  int            give_n = 0;
  bit            spur = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (fifo_deq_en) begin
        win_deq++;
        pend_pop = 1;
      end
      if (wr_req_valid) begin
        cap_addr.push_back(wr_req_addr);
        cap_md.push_back(wr_req_mdata);
        cap_data.push_back(wr_req_data);
        cap_cyc.push_back(cyc);
        win_req++;
        if (auto_rsp) give_n++;
      end
    end
  end

  // Pop and response driver, settled after main stimulus in the same step
  always @(posedge clk) begin
    cyc++;
    #2;
    if (pend_pop) begin
      if (fq.size() > 0) void'(fq.pop_front());
      pend_pop = 0;
      refresh();
    end
    if (give_n > 0) begin
      wr_rsp_valid = 1'b1;
      give_n--;
    end else begin
      wr_rsp_valid = spur;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_cap();
    cap_addr.delete();
    cap_md.delete();
    cap_data.delete();
    cap_cyc.delete();
    win_deq = 0;
    win_req = 0;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [LW-1:0] n);
    wr_base_addr = b;
    num_lines    = n;
    start        = 1'b1;
    tick(1);
    start        = 1'b0;
  endtask

  task automatic wait_reqs(input int n, input int budget, input string tag);
    int k = 0;
    while (cap_addr.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, cap_addr.size(), n);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (!done && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  logic [AW-1:0] wrap_exp[4];

  initial begin
    wrap_exp[0] = 42'h3FF_FFFF_FFFE;
    wrap_exp[1] = 42'h3FF_FFFF_FFFF;
    wrap_exp[2] = 42'h000_0000_0000;
    wrap_exp[3] = 42'h000_0000_0001;

    // Reset state
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req_valid", wr_req_valid, 0);
    chk("rst_deq_en", fifo_deq_en, 0);
    chk("rst_lines", lines_written, 0);
    chk("rst_addr", wr_req_addr, 0);
    chk("rst_mdata", wr_req_mdata, 0);
    chk("rst_data", wr_req_data, 0);
    reset = 1'b1;
    tick(2);

    // Spurious ack in IDLE
    spur = 1;
    tick(1);
    spur = 0;
    tick(2);
    chk("spur_idle_lines", lines_written, 0);
    chk("spur_idle_done", done, 0);

    // Basic: 4 lines from 0x100
    clear_cap();
    for (int i = 0; i < 4; i++) push(pat(i));
    auto_rsp = 1;
    do_start(42'h100, 4);
    chk("basic_busy_after_start", busy, 1);
    wait_reqs(4, 20, "basic_req_count");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("basic_addr%0d", i), cap_addr[i], 42'h100 + i);
      chk($sformatf("basic_mdata%0d", i), cap_md[i], i);
      chk($sformatf("basic_data%0d", i), cap_data[i], pat(i));
    end
    chk("basic_back_to_back", cap_cyc[3] - cap_cyc[0], 3);
    wait_done(20, "basic_done");
    chk("basic_lines", lines_written, 4);
    chk("basic_busy_low", busy, 0);
    tick(3);
    chk("basic_done_holds", done, 1);

    // Spurious ack in DONE
    spur = 1;
    tick(1);
    spur = 0;
    tick(2);
    chk("spur_done_lines", lines_written, 4);

    // Back-pressure mid-job
    clear_cap();
    for (int i = 0; i < 8; i++) push(pat(10 + i));
    do_start(42'h200, 8);
    wait_reqs(2, 20, "bp_first_reqs");
    wr_almost_full = 1'b1;
    tick(1);
    win_deq = 0;
    win_req = 0;
    tick(9);
    chk("bp_no_deq", win_deq, 0);
    chk("bp_no_req", win_req, 0);
    wr_almost_full = 1'b0;
    wait_reqs(8, 40, "bp_req_count");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp_addr%0d", i), cap_addr[i], 42'h200 + i);
      chk($sformatf("bp_data%0d", i), cap_data[i], pat(10 + i));
    end
    wait_done(30, "bp_done");
    chk("bp_lines", lines_written, 8);

    // Outstanding limit (MAX_OUTSTANDING = 4), responses withheld
    auto_rsp = 0;
    clear_cap();
    for (int i = 0; i < 10; i++) push(pat(20 + i));
    do_start(42'h300, 10);
    tick(15);
    chk("ost_req_cap", cap_addr.size(), 4);
    chk("ost_deq_cap", win_deq, 4);
    give_n = 1;
    tick(6);
    chk("ost_one_release", cap_addr.size(), 5);
    give_n = 2;
    tick(6);
    chk("ost_two_release", cap_addr.size(), 7);
    auto_rsp = 1;
    give_n = 4;
    wait_reqs(10, 40, "ost_req_count");
    for (int i = 0; i < 10; i++) chk($sformatf("ost_mdata%0d", i), cap_md[i], i);
    wait_done(30, "ost_done");
    chk("ost_lines", lines_written, 10);

    // Zero length
    clear_cap();
    push(pat(99));
    do_start(42'h500, 0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    tick(3);
    chk("zero_no_deq", win_deq, 0);
    chk("zero_lines", lines_written, 0);

    // FIFO empties mid-job, then refills
    clear_cap();
    push(pat(30));
    push(pat(31));
    do_start(42'h600, 5);
    tick(10);
    chk("empty_stall_reqs", cap_addr.size(), 3);
    chk("empty_stall_busy", busy, 1);
    push(pat(32));
    push(pat(33));
    wait_reqs(5, 20, "empty_req_count");
    chk("empty_data0", cap_data[0], pat(99));
    chk("empty_data1", cap_data[1], pat(30));
    chk("empty_data2", cap_data[2], pat(31));
    chk("empty_data3", cap_data[3], pat(32));
    chk("empty_data4", cap_data[4], pat(33));
    chk("empty_addr4", cap_addr[4], 42'h604);
    wait_done(30, "empty_done");
    chk("empty_lines", lines_written, 5);

    // Address wrap
    clear_cap();
    for (int i = 0; i < 4; i++) push(pat(50 + i));
    do_start(42'h3FF_FFFF_FFFE, 4);
    wait_reqs(4, 20, "wrap_req_count");
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_addr%0d", i), cap_addr[i], wrap_exp[i]);
    wait_done(30, "wrap_done");

    // Reset mid-job
    auto_rsp = 0;
    clear_cap();
    for (int i = 0; i < 8; i++) push(pat(60 + i));
    do_start(42'h700, 8);
    wait_reqs(2, 20, "mid_first_reqs");
    reset = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_req_valid", wr_req_valid, 0);
    chk("mid_deq_en", fifo_deq_en, 0);
    chk("mid_addr", wr_req_addr, 0);
    chk("mid_mdata", wr_req_mdata, 0);
    chk("mid_lines", lines_written, 0);
    give_n = 0;
    fq.delete();
    refresh();
    tick(2);
    reset = 1'b1;
    tick(2);
    clear_cap();
    push(pat(70));
    push(pat(71));
    auto_rsp = 1;
    do_start(42'h40, 2);
    wait_reqs(2, 20, "post_req_count");
    chk("post_addr0", cap_addr[0], 42'h40);
    chk("post_addr1", cap_addr[1], 42'h41);
    chk("post_mdata0", cap_md[0], 0);
    chk("post_mdata1", cap_md[1], 1);
    chk("post_data1", cap_data[1], pat(71));
    wait_done(30, "post_done");
    chk("post_lines", lines_written, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
